// File: rtl/l2_mem_side_intf_pkg.sv
// Message encodings shared by the L2 and the memory-side interface.
// Constants only; no logic, latency or backpressure of its own.
package l2_mem_side_intf_pkg;

    localparam int MSG_ENC_BITS = 4;

    localparam logic [MSG_ENC_BITS-1:0] NO_REQ    = 4'd0;
    localparam logic [MSG_ENC_BITS-1:0] R_REQ     = 4'd1;
    localparam logic [MSG_ENC_BITS-1:0] RFO_BCAST = 4'd2;
    localparam logic [MSG_ENC_BITS-1:0] WB_REQ    = 4'd3;
    localparam logic [MSG_ENC_BITS-1:0] C_FLUSH   = 4'd4;
    localparam logic [MSG_ENC_BITS-1:0] REQ_FLUSH = 4'd5;
    localparam logic [MSG_ENC_BITS-1:0] MEM_RESP  = 4'd6;

endpackage

// File: rtl/l2_mem_side_intf.sv
// Bridges L2 line requests and external flushes to a single-outstanding memory port.
// Latency: request enters memory port one cycle after acceptance; read response after data return + 1.
// Backpressure: mem_req_valid/payload held until mem_req_ready; hierarchy honours mem_intf_busy.
module l2_mem_side_intf
    import l2_mem_side_intf_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int MSG_BITS     = 4,
    parameter int OFFSET_BITS  = 2,
    parameter int LINE_WIDTH   = (1 << OFFSET_BITS) * DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [MSG_BITS-1:0]     cachehier2mem_msg,
    input  logic [ADDRESS_BITS-1:0] cachehier2mem_address,
    input  logic [LINE_WIDTH-1:0]   cachehier2mem_data,
    output logic [MSG_BITS-1:0]     mem2cachehier_msg,
    output logic [ADDRESS_BITS-1:0] mem2cachehier_address,
    output logic [LINE_WIDTH-1:0]   mem2cachehier_data,
    output logic                    mem_intf_busy,
    output logic [ADDRESS_BITS-1:0] mem_intf_address,
    output logic                    mem_intf_address_valid,
    input  logic                    flush_req,
    input  logic [ADDRESS_BITS-1:0] flush_address,
    output logic                    flush_done,
    output logic                    mem_req_valid,
    output logic                    mem_req_write,
    output logic [ADDRESS_BITS-1:0] mem_req_address,
    output logic [LINE_WIDTH-1:0]   mem_req_data,
    input  logic                    mem_req_ready,
    input  logic                    mem_resp_valid,
    input  logic [LINE_WIDTH-1:0]   mem_resp_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] RESPOND = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;
    localparam logic [2:0] FL_CMD  = 3'd5;
    localparam logic [2:0] FL_WAIT = 3'd6;

    localparam logic [MSG_BITS-1:0] M_NO_REQ    = MSG_BITS'(NO_REQ);
    localparam logic [MSG_BITS-1:0] M_R_REQ     = MSG_BITS'(R_REQ);
    localparam logic [MSG_BITS-1:0] M_RFO_BCAST = MSG_BITS'(RFO_BCAST);
    localparam logic [MSG_BITS-1:0] M_WB_REQ    = MSG_BITS'(WB_REQ);
    localparam logic [MSG_BITS-1:0] M_C_FLUSH   = MSG_BITS'(C_FLUSH);
    localparam logic [MSG_BITS-1:0] M_REQ_FLUSH = MSG_BITS'(REQ_FLUSH);
    localparam logic [MSG_BITS-1:0] M_MEM_RESP  = MSG_BITS'(MEM_RESP);

    logic [2:0]              state;
    logic [ADDRESS_BITS-1:0] addr_reg;
    logic [LINE_WIDTH-1:0]   data_reg;
    logic                    from_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_reg   <= '0;
            data_reg   <= '0;
            from_flush <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Hierarchy traffic wins over an external flush in the same cycle.
                    if (cachehier2mem_msg == M_R_REQ || cachehier2mem_msg == M_RFO_BCAST) begin
                        addr_reg <= cachehier2mem_address;
                        state    <= RD_REQ;
                    end else if (cachehier2mem_msg == M_WB_REQ || cachehier2mem_msg == M_C_FLUSH) begin
                        addr_reg   <= cachehier2mem_address;
                        data_reg   <= cachehier2mem_data;
                        from_flush <= 1'b0;
                        state      <= WR_REQ;
                    end else if (flush_req) begin
                        addr_reg <= flush_address;
                        state    <= FL_CMD;
                    end
                end
                RD_REQ:  if (mem_req_ready) state <= RD_WAIT;
                RD_WAIT: begin
                    if (mem_resp_valid) begin
                        data_reg <= mem_resp_data;
                        state    <= RESPOND;
                    end
                end
                RESPOND: state <= IDLE;
                WR_REQ: begin
                    if (mem_req_ready) begin
                        from_flush <= 1'b0;
                        state      <= IDLE;
                    end
                end
                FL_CMD:  state <= FL_WAIT;
                FL_WAIT: begin
                    if (cachehier2mem_msg == M_C_FLUSH && cachehier2mem_address == addr_reg) begin
                        data_reg   <= cachehier2mem_data;
                        from_flush <= 1'b1;
                        state      <= WR_REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem2cachehier_msg     = M_NO_REQ;
        mem2cachehier_address = '0;
        mem2cachehier_data    = '0;
        mem_req_valid         = 1'b0;
        mem_req_write         = 1'b0;
        mem_req_address       = '0;
        mem_req_data          = '0;
        flush_done            = 1'b0;
        case (state)
            RESPOND: begin
                mem2cachehier_msg     = M_MEM_RESP;
                mem2cachehier_address = addr_reg;
                mem2cachehier_data    = data_reg;
            end
            FL_CMD: begin
                mem2cachehier_msg     = M_REQ_FLUSH;
                mem2cachehier_address = addr_reg;
            end
            RD_REQ: begin
                mem_req_valid   = 1'b1;
                mem_req_address = addr_reg;
            end
            WR_REQ: begin
                mem_req_valid   = 1'b1;
                mem_req_write   = 1'b1;
                mem_req_address = addr_reg;
                mem_req_data    = data_reg;
                flush_done      = from_flush && mem_req_ready;
            end
            default: ;
        endcase
    end

    assign mem_intf_busy          = (state != IDLE);
    assign mem_intf_address_valid = (state != IDLE);
    assign mem_intf_address       = addr_reg;

endmodule

// File: tb/tb_l2_mem_side_intf.sv
// Directed bench for l2_mem_side_intf: read, flush, stalled writeback, priority and reset cases.
module tb_l2_mem_side_intf;
    import l2_mem_side_intf_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   cachehier2mem_msg;
    logic [31:0]  cachehier2mem_address;
    logic [127:0] cachehier2mem_data;
    logic [3:0]   mem2cachehier_msg;
    logic [31:0]  mem2cachehier_address;
    logic [127:0] mem2cachehier_data;
    logic         mem_intf_busy;
    logic [31:0]  mem_intf_address;
    logic         mem_intf_address_valid;
    logic         flush_req;
    logic [31:0]  flush_address;
    logic         flush_done;
    logic         mem_req_valid;
    logic         mem_req_write;
    logic [31:0]  mem_req_address;
    logic [127:0] mem_req_data;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] RD_LINE = 128'h00040004_00030003_00020002_00010001;
    localparam logic [127:0] FL_LINE = 128'h11112222_00030003_00020002_00010001;
    localparam logic [127:0] WB_LINE = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [127:0] JUNK    = 128'h55555555_66666666_77777777_88888888;

    always #5 clock = ~clock;

    l2_mem_side_intf dut (
        .clock                  (clock),
        .reset                  (reset),
        .cachehier2mem_msg      (cachehier2mem_msg),
        .cachehier2mem_address  (cachehier2mem_address),
        .cachehier2mem_data     (cachehier2mem_data),
        .mem2cachehier_msg      (mem2cachehier_msg),
        .mem2cachehier_address  (mem2cachehier_address),
        .mem2cachehier_data     (mem2cachehier_data),
        .mem_intf_busy          (mem_intf_busy),
        .mem_intf_address       (mem_intf_address),
        .mem_intf_address_valid (mem_intf_address_valid),
        .flush_req              (flush_req),
        .flush_address          (flush_address),
        .flush_done             (flush_done),
        .mem_req_valid          (mem_req_valid),
        .mem_req_write          (mem_req_write),
        .mem_req_address        (mem_req_address),
        .mem_req_data           (mem_req_data),
        .mem_req_ready          (mem_req_ready),
        .mem_resp_valid         (mem_resp_valid),
        .mem_resp_data          (mem_resp_data)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic hier(input logic [3:0] msg, input logic [31:0] addr, input logic [127:0] data);
        cachehier2mem_msg     = msg;
        cachehier2mem_address = addr;
        cachehier2mem_data    = data;
    endtask

    initial begin
        reset = 1'b1;
        hier(NO_REQ, 32'h0, 128'h0);
        flush_req      = 1'b0;
        flush_address  = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 128'h0;
        step();
        step();
        #1;
        check("rst_busy",    mem_intf_busy, 0);
        check("rst_avld",    mem_intf_address_valid, 0);
        check("rst_msg",     mem2cachehier_msg, NO_REQ);
        check("rst_reqvld",  mem_req_valid, 0);
        check("rst_fdone",   flush_done, 0);
        check("rst_ifaddr",  mem_intf_address, 0);
        reset = 1'b0;

        // RFO read: ready one cycle after the request, data three cycles later.
        hier(RFO_BCAST, 32'h3fffffc0, 128'h0);
        step();
        hier(NO_REQ, 32'h0, 128'h0);
        check("rd_busy",   mem_intf_busy, 1);
        check("rd_vld",    mem_req_valid, 1);
        check("rd_wr",     mem_req_write, 0);
        check("rd_addr",   mem_req_address, 32'h3fffffc0);
        check("rd_ifaddr", mem_intf_address, 32'h3fffffc0);
        check("rd_msg0",   mem2cachehier_msg, NO_REQ);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("rd_wait_vld", mem_req_valid, 0);
        for (int i = 0; i < 2; i++) begin
            check("rd_wait_busy", mem_intf_busy, 1);
            check("rd_wait_msg",  mem2cachehier_msg, NO_REQ);
            step();
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = RD_LINE;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 128'h0;
        check("resp_msg",  mem2cachehier_msg, MEM_RESP);
        check("resp_addr", mem2cachehier_address, 32'h3fffffc0);
        check("resp_data", mem2cachehier_data, RD_LINE);
        check("resp_busy", mem_intf_busy, 1);
        step();
        check("resp_end_msg",  mem2cachehier_msg, NO_REQ);
        check("resp_end_data", mem2cachehier_data, 0);
        check("resp_end_busy", mem_intf_busy, 0);

        // External flush, with a non-matching C_FLUSH ignored first.
        flush_req     = 1'b1;
        flush_address = 32'h3fffffc0;
        step();
        flush_req = 1'b0;
        check("fl_cmd_msg",  mem2cachehier_msg, REQ_FLUSH);
        check("fl_cmd_addr", mem2cachehier_address, 32'h3fffffc0);
        check("fl_cmd_data", mem2cachehier_data, 0);
        check("fl_cmd_busy", mem_intf_busy, 1);
        step();
        check("fl_wait_msg", mem2cachehier_msg, NO_REQ);
        hier(C_FLUSH, 32'h00000020, JUNK);
        step();
        check("fl_ign_vld",  mem_req_valid, 0);
        check("fl_ign_busy", mem_intf_busy, 1);
        hier(C_FLUSH, 32'h3fffffc0, FL_LINE);
        step();
        hier(NO_REQ, 32'h0, 128'h0);
        check("fl_wr_vld",   mem_req_valid, 1);
        check("fl_wr_wr",    mem_req_write, 1);
        check("fl_wr_addr",  mem_req_address, 32'h3fffffc0);
        check("fl_wr_data",  mem_req_data, FL_LINE);
        check("fl_nodone",   flush_done, 0);
        mem_req_ready = 1'b1;
        #1;
        check("fl_done",     flush_done, 1);
        step();
        mem_req_ready = 1'b0;
        check("fl_done_end", flush_done, 0);
        check("fl_idle",     mem_intf_busy, 0);

        // Writeback stalled by memory for five cycles.
        hier(WB_REQ, 32'h00000010, WB_LINE);
        step();
        hier(NO_REQ, 32'h0, 128'h0);
        for (int i = 0; i < 5; i++) begin
            check("wb_vld",  mem_req_valid, 1);
            check("wb_wr",   mem_req_write, 1);
            check("wb_addr", mem_req_address, 32'h00000010);
            check("wb_data", mem_req_data, WB_LINE);
            check("wb_msg",  mem2cachehier_msg, NO_REQ);
            step();
        end
        mem_req_ready = 1'b1;
        #1;
        check("wb_nodone", flush_done, 0);
        step();
        mem_req_ready = 1'b0;
        check("wb_idle", mem_intf_busy, 0);
        check("wb_vld0", mem_req_valid, 0);

        // Read and flush presented together: read first, flush after IDLE.
        hier(R_REQ, 32'h00000100, 128'h0);
        flush_req     = 1'b1;
        flush_address = 32'h00000200;
        step();
        hier(NO_REQ, 32'h0, 128'h0);
        check("pri_rd_addr", mem_req_address, 32'h00000100);
        check("pri_rd_wr",   mem_req_write, 0);
        check("pri_no_fl",   mem2cachehier_msg, NO_REQ);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = WB_LINE;
        step();
        mem_resp_valid = 1'b0;
        check("pri_resp", mem2cachehier_msg, MEM_RESP);
        check("pri_resp_data", mem2cachehier_data, WB_LINE);
        step();
        check("pri_idle", mem_intf_busy, 0);
        step();
        flush_req = 1'b0;
        check("pri_fl_msg",  mem2cachehier_msg, REQ_FLUSH);
        check("pri_fl_addr", mem2cachehier_address, 32'h00000200);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Reset in RD_WAIT drops the read.
        hier(R_REQ, 32'h00000040, 128'h0);
        step();
        hier(NO_REQ, 32'h0, 128'h0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("rw_busy", mem_intf_busy, 1);
        reset = 1'b1;
        #1;
        check("rw_rst_busy",   mem_intf_busy, 0);
        check("rw_rst_avld",   mem_intf_address_valid, 0);
        check("rw_rst_ifaddr", mem_intf_address, 0);
        step();
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = RD_LINE;
        step();
        mem_resp_valid = 1'b0;
        check("rw_late_msg",  mem2cachehier_msg, NO_REQ);
        check("rw_late_busy", mem_intf_busy, 0);
        step();
        check("rw_late_msg2", mem2cachehier_msg, NO_REQ);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/l2_mem_side_intf.md
L2_MEM_SIDE_INTF -- requirements
Module: l2_mem_side_intf

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one word.
REQ-002 Parameter ADDRESS_BITS, default 32, width of a line address.
REQ-003 Parameter MSG_BITS, default 4, width of message fields.
REQ-004 Parameter OFFSET_BITS, default 2, log2 of words per L2 line; LINE_WIDTH = (1<<OFFSET_BITS)*DATA_WIDTH (128).
REQ-005 Clock and reset SHALL be: one clock, named clock; reset is asynchronous and active-high, named reset.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 cachehier2mem_msg/address/data  input  MSG_BITS/ADDRESS_BITS/LINE_WIDTH  request from cache hierarchy.
REQ-009 mem2cachehier_msg/address/data  output  MSG_BITS/ADDRESS_BITS/LINE_WIDTH  response or command to hierarchy.
REQ-010 mem_intf_busy  output  1  transaction in progress.
REQ-011 mem_intf_address, mem_intf_address_valid  output  ADDRESS_BITS, 1  address of the in-flight transaction.
REQ-012 flush_req, flush_address  input  1, ADDRESS_BITS  external request to pull one line out of the hierarchy.
REQ-013 flush_done  output  1  one-cycle pulse when the flushed line has reached memory.
REQ-014 mem_req_valid, mem_req_write  output  1, 1  memory request strobe and direction.
REQ-015 mem_req_address, mem_req_data  output  ADDRESS_BITS, LINE_WIDTH  memory request payload.
REQ-016 mem_req_ready  input  1  memory accepts request when high with mem_req_valid.
REQ-017 mem_resp_valid, mem_resp_data  input  1, LINE_WIDTH  read data return.

Function
REQ-018 States SHALL be IDLE, RD_REQ, RD_WAIT, RESPOND, WR_REQ, FL_CMD, FL_WAIT.
REQ-019 In IDLE, R_REQ or RFO_BCAST SHALL latch address and go to RD_REQ next cycle.
REQ-020 In IDLE, WB_REQ or C_FLUSH SHALL latch address and data and go to WR_REQ.
REQ-021 Hierarchy requests SHALL have priority over flush_req in the same cycle; flush_req SHALL be held by its source until accepted.
REQ-022 In IDLE with flush_req and no hierarchy request, the block SHALL latch flush_address and go to FL_CMD.
REQ-023 mem_intf_busy and mem_intf_address_valid SHALL be 1 in every state except IDLE; mem_intf_address SHALL equal the latched address.
REQ-024 RD_REQ: mem_req_valid=1, mem_req_write=0; on mem_req_ready go to RD_WAIT; valid and payload stay stable until accepted.
REQ-025 RD_WAIT: on mem_resp_valid latch mem_resp_data and go to RESPOND.
REQ-026 RESPOND: drive MEM_RESP, latched address and data for exactly one cycle, then IDLE.
REQ-027 WR_REQ: mem_req_valid=1, mem_req_write=1; on mem_req_ready go to IDLE, emitting no message; if the write came from FL_WAIT, pulse flush_done in that cycle.
REQ-028 FL_CMD: drive REQ_FLUSH with latched address for exactly one cycle, then FL_WAIT.
REQ-029 FL_WAIT: on C_FLUSH with matching address, latch data and go to WR_REQ. Non-matching messages SHALL be ignored.
REQ-030 mem2cachehier_msg SHALL be NO_REQ, and address and data zero, whenever no message is driven.
REQ-031 Hierarchy requests arriving while busy SHALL be ignored; the hierarchy honours mem_intf_busy.
REQ-032 Addresses SHALL pass through unmodified as line addresses; no arithmetic.

Reset
REQ-033 reset SHALL force IDLE immediately, including mid-transaction; the in-flight transaction is dropped.
REQ-034 On reset, all outputs SHALL be 0, mem2cachehier_msg SHALL be NO_REQ, and all latched registers SHALL be cleared.

Structure
REQ-035 Message encodings (NO_REQ, R_REQ, RFO_BCAST, WB_REQ, C_FLUSH, REQ_FLUSH, MEM_RESP) SHALL come from the shared params include, not local redefinitions.
REQ-036 State encodings SHALL be localparams inside the module; no sub-module is required.

Verification
REQ-037 RFO_BCAST to 0x3fffffc0; memory ready the next cycle, data 0x00040004_00030003_00020002_00010001 after 3 cycles -> one-cycle MEM_RESP with that address and data; busy is high throughout.
REQ-038 flush_req to 0x3fffffc0; hierarchy answers C_FLUSH with data 0x11112222_00030003_00020002_00010001 -> one-cycle REQ_FLUSH; memory write with that data; one flush_done pulse.
REQ-039 WB_REQ to 0x00000010 with mem_req_ready held low for 5 cycles -> mem_req_valid and payload stable for 5 cycles; no message is emitted.
REQ-040 R_REQ and flush_req in the same cycle -> the read is serviced first; REQ_FLUSH follows after return to IDLE.
REQ-041 reset asserted during RD_WAIT -> outputs are cleared immediately; a later mem_resp_valid produces no MEM_RESP.
REQ-042 In FL_WAIT, C_FLUSH to 0x00000020 arrives -> it is ignored; the matching C_FLUSH completes the flush.
